// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked program image over
// UART 8N1 and writes it word by word into instruction memory.
`timescale 1ns/1ps
module imem_uart_loader #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(CPB) + 1;
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_e;

  logic             rx_s1_q;
  logic             rx_s2_q;
  logic             rx_prev_q;
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  // Receiver: bit timing is measured from the cycle the falling edge is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s1_q      <= uart_rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
            cnt_q      <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q        <= '0;
            byte_valid_q <= rx_s2_q;
            frame_err_q  <= !rx_s2_q;
            rx_state_q   <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  state_e           state_q;
  logic [15:0]      len_q;
  logic [16:0]      words_q;
  logic [1:0]       bidx_q;
  logic [23:0]      wbuf_q;
  logic [7:0]       csum_q;
  logic             we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             rstn_q;
  logic             done_q;
  logic             err_q;
  logic [15:0]      len_d;

  assign len_d = {shift_q, len_q[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN_LO;
      len_q   <= '0;
      words_q <= '0;
      bidx_q  <= '0;
      wbuf_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rstn_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (frame_err_q && state_q != S_DONE) begin
        state_q <= S_ERROR;
        err_q   <= 1'b1;
        done_q  <= 1'b0;
        rstn_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_LEN_LO: begin
            if (byte_valid_q) begin
              len_q[7:0] <= shift_q;
              state_q    <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (byte_valid_q) begin
              len_q   <= len_d;
              words_q <= '0;
              bidx_q  <= '0;
              csum_q  <= '0;
              if ({1'b0, len_d} > MAX_WORDS) begin
                state_q <= S_ERROR;
                err_q   <= 1'b1;
              end else if (len_d == 16'd0) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            // Strobe cycle: advance address, or leave once the last word is out.
            if (we_q) begin
              if (words_q == {1'b0, len_q}) state_q <= S_CSUM;
              else addr_q <= addr_q + ADDR_W'(1);
            end else if (byte_valid_q) begin
              csum_q <= csum_q ^ shift_q;
              bidx_q <= bidx_q + 1'b1;
              unique case (bidx_q)
                2'd0: wbuf_q[7:0]   <= shift_q;
                2'd1: wbuf_q[15:8]  <= shift_q;
                2'd2: wbuf_q[23:16] <= shift_q;
                2'd3: begin
                  wdata_q <= {shift_q, wbuf_q};
                  we_q    <= 1'b1;
                  words_q <= words_q + 17'd1;
                end
                default: ;
              endcase
            end
          end
          S_CSUM: begin
            if (byte_valid_q) begin
              if (shift_q == csum_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                rstn_q  <= 1'b1;
              end else begin
                state_q <= S_ERROR;
                err_q   <= 1'b1;
              end
            end
          end
          S_DONE: ;
          S_ERROR: ;
          default: state_q <= S_ERROR;
        endcase
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rstn   = rstn_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
